// File: rtl/fetch_queue_stage_pkg.sv
// Shared architecture constants and types for the fetch queue stage.
// Instruction word layout, jump type code and the queued entry bundle.
package fetch_queue_stage_pkg;

  localparam int XLEN     = 32;
  localparam int ITYPE_W  = 5;
  localparam int ITYPE_HI = 31;
  localparam int ITYPE_LO = 27;

  localparam logic [ITYPE_W-1:0] ITYPE_JUMP = 5'b11000;
  localparam logic [XLEN-1:0]    NOP        = '0;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fq_entry_t;

  function automatic logic is_jump(input logic [XLEN-1:0] w);
    return w[ITYPE_HI:ITYPE_LO] == ITYPE_JUMP;
  endfunction

endpackage

// File: rtl/fetch_queue_stage_fifo.sv
// fetch_fifo: parameterised synchronous FIFO with single-cycle flush.
// The caller guarantees push only when not full (or popping) and pop only when non-empty.
module fetch_fifo #(
  parameter  int DEPTH = 2,
  parameter  int W     = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wptr_q] <= din;
  end

  assign dout  = mem_q[rptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/fetch_queue_stage.sv
// Fetch stage: owns the PC, fetches into a small queue, handles redirects.
// Optional FETCH_JUMP_HOLD_EN: stall fetch after a jump word until resolved.
module fetch_queue_stage
  import fetch_queue_stage_pkg::*;
#(
  parameter  int              DEPTH    = 2,
  parameter  logic [XLEN-1:0] RESET_PC = '0,
  localparam int              CW       = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_raddr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] instr_pc_out,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
`ifdef FETCH_JUMP_HOLD_EN
  input  logic            jump_resolved,
`endif
  output logic [CW-1:0]   fifo_count
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            push, pop, room, hold;
  fq_entry_t       wr_e, rd_e;

  assign instr_valid = fifo_count != '0;
  assign room        = fifo_count < CW'(DEPTH);
  assign pop  = instr_valid && instr_ready && !redirect_valid;
  assign push = !redirect_valid && !hold && (room || pop);

`ifdef FETCH_JUMP_HOLD_EN
  logic hold_q, hold_d;

  always_comb begin
    hold_d = hold_q;
    if (redirect_valid || jump_resolved) hold_d = 1'b0;
    else if (push && is_jump(imem_rdata)) hold_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_q <= 1'b0;
    else     hold_q <= hold_d;
  end

  assign hold = hold_q;
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) pc_d = redirect_addr;
    else if (push)      pc_d = pc_q + XLEN'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign wr_e = '{instr: imem_rdata, pc: pc_q};

  fetch_fifo #(
    .DEPTH(DEPTH),
    .W    ($bits(fq_entry_t))
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .flush(redirect_valid),
    .push (push),
    .pop  (pop),
    .din  (wr_e),
    .dout (rd_e),
    .count(fifo_count)
  );

  assign imem_raddr   = pc_q;
  assign instr_out    = instr_valid ? rd_e.instr : NOP;
  assign instr_pc_out = instr_valid ? rd_e.pc    : '0;

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Self-checking bench for fetch_queue_stage: vector table, streaming
// scoreboard, async reset and (when enabled) jump-hold sequences.
module tb_fetch_queue_stage;
  import fetch_queue_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_raddr, imem_rdata;
  logic [31:0] instr_out, instr_pc_out;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        jump_resolved = 1'b0;
  logic [1:0]  fifo_count;
  logic [31:0] jump_addr = 32'hFFFF_FF00;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_rdata = (imem_raddr == jump_addr) ?
                      {ITYPE_JUMP, 27'h5} : 32'h1000 + imem_raddr;

  fetch_queue_stage #(.DEPTH(2), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_raddr    (imem_raddr),
    .imem_rdata    (imem_rdata),
    .instr_out     (instr_out),
    .instr_pc_out  (instr_pc_out),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
`ifdef FETCH_JUMP_HOLD_EN
    .jump_resolved (jump_resolved),
`endif
    .fifo_count    (fifo_count)
  );

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] ra;
    logic        e_valid;
    logic [31:0] e_out;
    logic [31:0] e_pc;
    logic [1:0]  e_cnt;
    logic [31:0] e_raddr;
  } vec_t;

  vec_t        vt[14];
  logic [31:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    jump_resolved = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    for (int k = 0; k < 6 && !instr_valid; k++) tick();
    chk(nm, {31'h0, instr_valid}, 32'h1);
  endtask

  initial begin
    vt[0]  = '{0, 0, 0,        1, 32'h1000, 32'h0,  2'd1, 32'h1};
    vt[1]  = '{0, 0, 0,        1, 32'h1000, 32'h0,  2'd2, 32'h2};
    vt[2]  = '{0, 0, 0,        1, 32'h1000, 32'h0,  2'd2, 32'h2};
    vt[3]  = '{0, 0, 0,        1, 32'h1000, 32'h0,  2'd2, 32'h2};
    vt[4]  = '{1, 0, 0,        1, 32'h1001, 32'h1,  2'd2, 32'h3};
    vt[5]  = '{1, 0, 0,        1, 32'h1002, 32'h2,  2'd2, 32'h4};
    vt[6]  = '{1, 1, 32'h40,   0, 32'h0,    32'h0,  2'd0, 32'h40};
    vt[7]  = '{0, 0, 0,        1, 32'h1040, 32'h40, 2'd1, 32'h41};
    vt[8]  = '{1, 1, 32'h80,   0, 32'h0,    32'h0,  2'd0, 32'h80};
    vt[9]  = '{1, 0, 0,        1, 32'h1080, 32'h80, 2'd1, 32'h81};
    vt[10] = '{1, 0, 0,        1, 32'h1081, 32'h81, 2'd1, 32'h82};
    vt[11] = '{0, 1, '1,       0, 32'h0,    32'h0,  2'd0, 32'hFFFFFFFF};
    vt[12] = '{0, 0, 0,        1, 32'h0FFF, '1,     2'd1, 32'h0};
    vt[13] = '{0, 0, 0,        1, 32'h0FFF, '1,     2'd2, 32'h1};

    do_reset();
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_out",   instr_out,    32'h0);
    chk("rst_pc",    instr_pc_out, 32'h0);
    chk("rst_raddr", imem_raddr,   32'h0);
    chk("rst_count", {30'h0, fifo_count}, 32'h0);

    for (int i = 0; i < 14; i++) begin
      instr_ready    = vt[i].rdy;
      redirect_valid = vt[i].rv;
      redirect_addr  = vt[i].ra;
      tick();
      chk($sformatf("v%0d_valid", i), {31'h0, instr_valid},
          {31'h0, vt[i].e_valid});
      chk($sformatf("v%0d_out", i), instr_out, vt[i].e_out);
      chk($sformatf("v%0d_pc", i), instr_pc_out, vt[i].e_pc);
      chk($sformatf("v%0d_cnt", i), {30'h0, fifo_count},
          {30'h0, vt[i].e_cnt});
      chk($sformatf("v%0d_raddr", i), imem_raddr, vt[i].e_raddr);
    end
    redirect_valid = 1'b0;

    // Streaming with a 5-cycle decode stall in the middle.
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 40; i++) exp_q.push_back(32'(i));
    begin
      int consumed = 0;
      for (int c = 0; c < 30; c++) begin
        tick();
        instr_ready = !(c >= 8 && c <= 12);
        if (c == 0) chk("first_pc", instr_pc_out, 32'h0);
        if (c == 12) begin
          chk("stall_cnt", {30'h0, fifo_count}, 32'h2);
          chk("stall_raddr", imem_raddr, instr_pc_out + 32'h2);
        end
        if (instr_valid && instr_ready) begin
          if (exp_q.size() == 0) begin
            chk("sb_empty", 32'h1, 32'h0);
          end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            chk("sb_pc", instr_pc_out, e);
            chk("sb_instr", instr_out, 32'h1000 + e);
          end
          consumed++;
        end
      end
      chk("sb_consumed", 32'(consumed), 32'd25);
    end

    // Asynchronous reset with two queued entries.
    instr_ready = 1'b0;
    repeat (3) tick();
    chk("pre_rst_cnt", {30'h0, fifo_count}, 32'h2);
    @(negedge clk);
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr = 32'h77;
    #1;
    chk("arst_valid", {31'h0, instr_valid}, 32'h0);
    chk("arst_out", instr_out, 32'h0);
    chk("arst_cnt", {30'h0, fifo_count}, 32'h0);
    chk("arst_raddr", imem_raddr, 32'h0);
    tick();
    chk("rst_win_raddr", imem_raddr, 32'h0);
    redirect_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("restart_pc", instr_pc_out, 32'h0);
    chk("restart_out", instr_out, 32'h1000);

`ifdef FETCH_JUMP_HOLD_EN
    jump_addr = 32'h3;
    do_reset();
    instr_ready = 1'b1;
    repeat (10) tick();
    chk("hold_raddr", imem_raddr, 32'h4);
    chk("hold_drained", {31'h0, instr_valid}, 32'h0);
    jump_resolved = 1'b1;
    tick();
    jump_resolved = 1'b0;
    wait_valid("jr_valid");
    chk("jr_pc", instr_pc_out, 32'h4);

    do_reset();
    instr_ready = 1'b1;
    repeat (10) tick();
    chk("hold2_raddr", imem_raddr, 32'h4);
    redirect_valid = 1'b1;
    redirect_addr = 32'h10;
    tick();
    redirect_valid = 1'b0;
    wait_valid("rd_valid");
    chk("rd_pc", instr_pc_out, 32'h10);
    chk("rd_out", instr_out, 32'h1010);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
